// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues single-outstanding imem
// reads, buffers responses in a prefetch FIFO, flushes on redirect.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   redirect_valid/redirect_pc  branch redirect from writeback
//   imem_req/imem_addr          word read request, held until imem_ack
//   imem_ack/imem_rdata         response, data valid with ack
//   out_valid/out_instr/out_pc  FIFO head to decode
//   out_ready                   decode accepts head this cycle
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_t;

  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        pc_q;
  logic [31:0]        pc_d;
  logic [31:0]        addr_d;
  logic               req_d;
  logic [PTR_W:0]     cnt_q;
  logic [PTR_W:0]     cnt_d;
  logic [PTR_W-1:0]   rd_q;
  logic [PTR_W-1:0]   rd_d;
  logic [PTR_W-1:0]   wr_q;
  logic [PTR_W-1:0]   wr_d;
  logic [PTR_W+1:0]   occ;
  logic [63:0]        mem [DEPTH];
  logic [63:0]        head;
  logic               acked;
  logic               hold;
  logic               push;
  logic               pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  // Entry layout: {instr, pc}
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= {imem_rdata, imem_addr};
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      // an unacked request must still be drained, then discarded
      state_d = hold ? DROP : RUN;
    end else begin
      if (acked) begin
        state_d = RUN;
      end
      if (push) begin
        pc_d = imem_addr + 32'd4;
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
    // registered count only: a pop this cycle frees no slot yet
    occ    = {1'b0, cnt_q} + (PTR_W+2)'(push);
    req_d  = hold | redirect_valid | (occ < DEPTH_C);
    addr_d = hold ? imem_addr : pc_d;
  end

  always_comb begin
    acked     = imem_req & imem_ack;
    hold      = imem_req & ~imem_ack;
    push      = acked & (state_q == RUN) & ~redirect_valid;
    out_valid = (cnt_q != '0);
    pop       = out_valid & out_ready;
    head      = mem[rd_q];
    out_instr = out_valid ? head[63:32] : 32'h0;
    out_pc    = out_valid ? head[31:0] : 32'h0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized
// redirects/backpressure/latency against an in-order stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int n_chk = 0;
  int n_fail = 0;

  bit          ack_tied = 1'b0;
  int          fix_lat = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic [31:0] exp_pc = 32'h0;
  int          delivered = 0;
  bit          p_req = 1'b0;
  bit          p_ack = 1'b0;
  bit          p_redir = 1'b0;
  logic [31:0] p_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready)
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h1F2E};
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream model + memory model, all at the negedge
  always @(negedge clk) begin
    if (reset) begin
      exp_pc     = 32'h0;
      p_req      = 1'b0;
      p_ack      = 1'b0;
      p_redir    = 1'b0;
      wcnt       = 0;
      lat        = (fix_lat >= 0) ? fix_lat : 0;
      imem_ack   = ack_tied;
      imem_rdata = 32'hBAD0_BAD0;
    end else begin
      if (p_redir) check("flush", out_valid, 0);
      if (p_req && !p_ack)
        check("hold", {imem_req, imem_addr}, {1'b1, p_addr});
      if (imem_req) check("align", imem_addr[1:0], 0);
      if (out_valid && out_ready) begin
        check("out_pc", out_pc, exp_pc);
        check("out_instr", out_instr, img(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      if (p_ack) begin
        wcnt = 0;
        lat  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
      end else if (p_req) begin
        wcnt++;
      end
      imem_ack   = ack_tied || (imem_req && wcnt >= lat);
      imem_rdata = imem_req ? img(imem_addr) : 32'hBAD0_BAD0;
      p_req   = imem_req;
      p_addr  = imem_addr;
      p_ack   = imem_req && imem_ack;
      p_redir = redirect_valid;
    end
  end

  task automatic chk_rst_vals(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_instr"}, out_instr, 0);
    check({tag, "_pc"}, out_pc, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    chk_rst_vals("rst");
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int npush;
    logic [31:0] e;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;

    // zero-wait streaming from reset
    ack_tied = 1'b1;
    fix_lat = 0;
    out_ready = 1'b1;
    do_reset();
    tick();
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 0);
    check("t1_v0", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_pc", out_pc, 32'(i * 4));
      check("t1_instr", out_instr, img(32'(i * 4)));
    end

    // backpressure fills exactly DEPTH entries, then resumes
    out_ready = 1'b0;
    do_reset();
    npush = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req) npush++;
    end
    check("t2_pushes", npush, 4);
    check("t2_req_off", imem_req, 0);
    check("t2_head", out_pc, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t2_valid", out_valid, 1);
      check("t2_pc", out_pc, 32'(i * 4));
    end

    // redirect with a slow response in flight
    ack_tied = 1'b0;
    fix_lat = 2;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 200 && !(imem_req && imem_addr == 32'h20); i++)
      tick();
    check("t3_at20", {imem_req, imem_addr}, {1'b1, 32'h20});
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t3_drop_hold", {imem_req, imem_addr}, {1'b1, 32'h20});
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h100); i++)
      tick();
    check("t3_at100", {imem_req, imem_addr}, {1'b1, 32'h100});
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("t3_first", {out_valid, out_pc}, {1'b1, 32'h100});

    // redirect with a full FIFO, unaligned target
    ack_tied = 1'b1;
    fix_lat = 0;
    out_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    check("t4_full", {out_valid, imem_req}, 2'b10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", out_valid, 0);
    check("t4_req", {imem_req, imem_addr}, {1'b1, 32'h200});
    out_ready = 1'b1;
    tick();
    check("t4_head", {out_valid, out_pc}, {1'b1, 32'h200});

    // address wrap
    out_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("t5_req", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFF8});
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 32'hFFFF_FFF8 + 32'(i * 4);
      check("t5_pc", {out_valid, out_pc}, {1'b1, e});
    end

    // reset while discarding a pending response
    ack_tied = 1'b0;
    fix_lat = 3;
    out_ready = 1'b1;
    do_reset();
    tick();
    check("t6_req", {imem_req, imem_addr}, {1'b1, 32'h0});
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("t6_drop", {imem_req, imem_addr}, {1'b1, 32'h0});
    #1;
    reset = 1'b1;
    #1;
    chk_rst_vals("t6_async");
    tick();
    ack_tied = 1'b1;
    reset = 1'b0;
    chk_rst_vals("t6_rel");
    tick();
    check("t6_req1", {imem_req, imem_addr, out_valid}, {1'b1, 32'h0, 1'b0});
    tick();
    check("t6_first", {out_valid, out_pc}, {1'b1, 32'h0});
    check("t6_instr", out_instr, img(32'h0));

    // randomized redirects, backpressure and latency
    ack_tied = 1'b0;
    fix_lat = -1;
    do_reset();
    delivered = 0;
    repeat (3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      tick();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("progress", delivered > 300, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Sits directly upstream of the F/R pipeline register of the deep pipeline core.
- Owns the fetch PC and issues word reads to the instruction memory port.
- Buffers returned instructions in a small prefetch FIFO and presents them, with their PC, to the decode/register-read stage over a valid/ready handshake.
- Handles branch redirects from writeback. Any instruction fetched on the wrong path is flushed, including a response still in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  branch/BX/PC-write taken this cycle
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned read address
imem_ack  input  1  memory accepts request and returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
out_valid  output  1  FIFO head holds a valid instruction
out_instr  output  32  instruction at FIFO head
out_pc  output  32  address of out_instr
out_ready  input  1  downstream accepts head this cycle

Behaviour:
- Reset (async, any time, including mid-request):
  - fetch_pc=RESET_PC; FIFO empty (rd_ptr=wr_ptr=0, count=0).
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - discard flag cleared.
  - A response arriving during or after reset for a pre-reset request is ignored.
- Request rule:
  - At most one request is outstanding.
  - imem_req registered high when count + pending < DEPTH. pending = 1 while imem_req=1 and not yet acked.
  - The count used is the registered value; a same-cycle pop gives no credit.
  - Once imem_req=1, imem_addr is held stable until imem_ack.
  - Zero-wait memory (ack in the first req cycle) must sustain 1 fetch/cycle.
- Ack, normal:
  - Push {imem_rdata, imem_addr} into the FIFO.
  - fetch_pc <= imem_addr+4, 32-bit wrap: 32'hFFFF_FFFC -> 0.
  - imem_req stays high next cycle with the new address if space permits.
- Output:
  - out_valid = (count!=0); out_instr/out_pc = head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged. Legal when count==DEPTH only because that push slot was reserved; overflow is impossible by construction.
- FSM (2 states):
  - RUN: normal.
  - DROP: entered on a redirect while a request is outstanding and not acked that cycle.
    - In DROP, imem_req stays high at the old address until ack; that response is discarded.
    - Next state RUN, with a new request at redirect_pc if space permits.
- Redirect (redirect_valid=1), effective at the next edge:
  - FIFO cleared (count=0, out_valid=0 the next cycle).
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Redirect with simultaneous ack: data dropped, no DROP state, next request at redirect_pc.
  - Redirect with simultaneous out handshake: the popped entry is considered delivered; the downstream flush covers it.
  - Redirect while in DROP: update fetch_pc to the newest redirect_pc and remain in DROP.
  - Redirect has priority over push.
- Latency:
  - Redirect at cycle N, zero-wait memory: imem_req at the new address in N+1, ack in N+1, out_valid in N+2.
  - From reset deassert: first imem_req in cycle 1, first out_valid in cycle 2 with zero-wait memory.

Test Plan:
- Reset release, RESET_PC=0, ack tied 1, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles; out_instr matches memory image.
- out_ready=0, ack tied 1 -> exactly 4 pushes (pc 0..12), then imem_req=0. Raise out_ready -> head pc 0, stream resumes at 16 with no loss or duplicates.
- Memory with 3-cycle ack latency, redirect to 0x100 in the cycle after req at 0x20 -> response for 0x20 discarded, next imem_addr=0x100, out_pc=0x100 first.
- Redirect to 0x203 with the FIFO full (4 entries) -> out_valid=0 the next cycle; next fetch address 0x200.
- redirect_pc=0xFFFF_FFF8, zero-wait memory -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- Assert reset while in DROP with ack pending; deassert, then ack arrives -> ack ignored, FIFO empty, first fetch at RESET_PC, all outputs at reset values.
